// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: default widths,
// the response-owner encoding and the address legality check.
package imem_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    // A byte address is bad if it is not word aligned or lies beyond the memory.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned addr_w);
        logic [31:0] hi;
        hi = addr >> (addr_w + 2);
        return (addr[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch port, loader port and single memory port around the arbiter.
// The arbiter uses the slave view; requesters and the memory use the master view.
interface imem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              f_err;

    logic              l_req;
    logic              l_we;
    logic [31:0]       l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;
    logic              l_err;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output l_gnt, l_rvalid, l_rdata, l_err,
        output m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  l_gnt, l_rvalid, l_rdata, l_err,
        input  m_en, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/imem_starve_ctr.sv
// Counts consecutive loader wins while fetch is waiting; once the count hits
// STARVE_MAX the next contested cycle is forced to fetch.
module imem_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic f_req,
    input  logic f_gnt,
    input  logic l_gnt,
    output logic force_fetch
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (f_gnt || !f_req) begin
            cnt <= '0;
        end else if (l_gnt && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_fetch = (cnt == CNT_MAX);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: loader wins by default, fetch is
// forced in after STARVE_MAX loader wins; responses return one cycle later.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int DATA_W     = IMEM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input logic          clk,
    input logic          reset,
    imem_arbiter_if.slave bus
);
    logic   force_fetch;
    logic   f_bad, l_bad;
    logic   f_gnt, l_gnt;
    owner_e owner_q, owner_d;
    logic   err_q, err_d;
    logic   we_q, we_d;

    assign f_bad = addr_bad(bus.f_addr, ADDR_W);
    assign l_bad = addr_bad(bus.l_addr, ADDR_W);

    assign l_gnt = bus.l_req && !(bus.f_req && force_fetch);
    assign f_gnt = bus.f_req && !l_gnt;

    imem_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk         (clk),
        .reset       (reset),
        .f_req       (bus.f_req),
        .f_gnt       (f_gnt),
        .l_gnt       (l_gnt),
        .force_fetch (force_fetch)
    );

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        owner_d     = OWN_NONE;
        err_d       = 1'b0;
        we_d        = 1'b0;
        bus.m_en    = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        if (l_gnt) begin
            owner_d     = OWN_LOAD;
            err_d       = l_bad;
            we_d        = bus.l_we;
            bus.m_en    = !l_bad;
            bus.m_we    = !l_bad && bus.l_we;
            bus.m_addr  = bus.l_addr[ADDR_W+1:2];
            bus.m_wdata = bus.l_wdata;
        end else if (f_gnt) begin
            owner_d    = OWN_FETCH;
            err_d      = f_bad;
            bus.m_en   = !f_bad;
            bus.m_addr = bus.f_addr[ADDR_W+1:2];
        end
    end

    // Reset drops any in-flight response so no rvalid follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
            we_q    <= we_d;
        end
    end

    assign bus.f_gnt    = f_gnt;
    assign bus.l_gnt    = l_gnt;
    assign bus.f_rvalid = (owner_q == OWN_FETCH);
    assign bus.l_rvalid = (owner_q == OWN_LOAD);
    assign bus.f_err    = bus.f_rvalid && err_q;
    assign bus.l_err    = bus.l_rvalid && err_q;
    assign bus.f_rdata  = (bus.f_rvalid && !err_q) ? bus.m_rdata : '0;
    assign bus.l_rdata  = (bus.l_rvalid && !err_q && !we_q) ? bus.m_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural synchronous memory;
// each scenario task drives vectors and checks hand-computed expectations.
module tb_imem_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: contents mem[i] = 0xA0000000 + i after reset.
    logic [DATA_W-1:0] mem [1024];
    logic [DATA_W-1:0] m_rdata_r;
    assign bus.m_rdata = m_rdata_r;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 + i;
            m_rdata_r <= '0;
        end else if (bus.m_en) begin
            if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
            else          m_rdata_r <= mem[bus.m_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.f_req   = 1'b0;
        bus.f_addr  = '0;
        bus.l_req   = 1'b0;
        bus.l_we    = 1'b0;
        bus.l_addr  = '0;
        bus.l_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) step();
        checks++;
        if ({bus.f_rvalid, bus.l_rvalid, bus.f_err, bus.l_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", {bus.f_rvalid, bus.l_rvalid, bus.f_err, bus.l_err});
        end
        checks++;
        if ({bus.f_rdata, bus.l_rdata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_rdata got %h/%h exp 0/0", bus.f_rdata, bus.l_rdata);
        end
        reset = 1'b0;
        step();
        // Fetch granted in cycle t, reset sampled at the closing edge.
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h0;
        #1;
        checks++;
        if ({bus.f_gnt, bus.m_en} !== 2'b11) begin
            errors++;
            $display("FAIL reset_midread_gnt got %b exp 11", {bus.f_gnt, bus.m_en});
        end
        reset = 1'b1;
        step();
        checks++;
        if (bus.f_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_midread_t1 got %b exp 0", bus.f_rvalid);
        end
        reset = 1'b0;
        bus.f_req = 1'b0;
        step();
        checks++;
        if (bus.f_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_midread_t2 got %b exp 0", bus.f_rvalid);
        end
        checks++;
        if (dut.u_starve.cnt !== '0) begin
            errors++;
            $display("FAIL reset_starve_cnt got %0d exp 0", dut.u_starve.cnt);
        end
    endtask

    task automatic test_fetch_b2b();
        logic [31:0] exp_data [3];
        exp_data[0] = 32'hA000_0000;
        exp_data[1] = 32'hA000_0001;
        exp_data[2] = 32'hA000_0002;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            bus.f_req  = 1'b1;
            bus.f_addr = 32'(i * 4);
            #1;
            checks++;
            if (bus.f_gnt !== 1'b1) begin
                errors++;
                $display("FAIL fetch_b2b_gnt%0d got %b exp 1", i, bus.f_gnt);
            end
            step();
            checks++;
            if ({bus.f_rvalid, bus.f_err, bus.f_rdata} !== {2'b10, exp_data[i]}) begin
                errors++;
                $display("FAIL fetch_b2b_rsp%0d got v=%b e=%b d=%h exp v=1 e=0 d=%h",
                         i, bus.f_rvalid, bus.f_err, bus.f_rdata, exp_data[i]);
            end
        end
        idle_inputs();
        step();
        checks++;
        if (bus.f_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_b2b_end got %b exp 0", bus.f_rvalid);
        end
    endtask

    task automatic test_starvation();
        logic [9:0] exp_l;
        exp_l = 10'b11110_11110;
        idle_inputs();
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h24;
        bus.l_req  = 1'b1;
        bus.l_addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({bus.l_gnt, bus.f_gnt} !== {exp_l[9-i], !exp_l[9-i]}) begin
                errors++;
                $display("FAIL starve_cycle%0d got l=%b f=%b exp l=%b f=%b",
                         i, bus.l_gnt, bus.f_gnt, exp_l[9-i], !exp_l[9-i]);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_raw();
        idle_inputs();
        bus.l_req   = 1'b1;
        bus.l_we    = 1'b1;
        bus.l_addr  = 32'h10;
        bus.l_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({bus.l_gnt, bus.m_en, bus.m_we, bus.m_addr} !== {3'b111, 10'd4}) begin
            errors++;
            $display("FAIL raw_write got g=%b en=%b we=%b a=%0d exp 1 1 1 4",
                     bus.l_gnt, bus.m_en, bus.m_we, bus.m_addr);
        end
        step();
        checks++;
        if ({bus.l_rvalid, bus.l_err, bus.l_rdata} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL raw_wack got v=%b e=%b d=%h exp 1 0 0", bus.l_rvalid, bus.l_err, bus.l_rdata);
        end
        idle_inputs();
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h10;
        step();
        checks++;
        if ({bus.f_rvalid, bus.f_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL raw_read got v=%b d=%h exp 1 deadbeef", bus.f_rvalid, bus.f_rdata);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_misaligned();
        idle_inputs();
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h6;
        #1;
        checks++;
        if ({bus.f_gnt, bus.m_en} !== 2'b10) begin
            errors++;
            $display("FAIL misaligned_gnt got g=%b en=%b exp 1 0", bus.f_gnt, bus.m_en);
        end
        step();
        idle_inputs();
        checks++;
        if ({bus.f_rvalid, bus.f_err, bus.f_rdata} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL misaligned_rsp got v=%b e=%b d=%h exp 1 1 0", bus.f_rvalid, bus.f_err, bus.f_rdata);
        end
        step();
    endtask

    task automatic test_bad_write();
        idle_inputs();
        bus.l_req   = 1'b1;
        bus.l_we    = 1'b1;
        bus.l_addr  = 32'h1000;
        bus.l_wdata = 32'h1234_5678;
        #1;
        checks++;
        if ({bus.l_gnt, bus.m_en, bus.m_we} !== 3'b100) begin
            errors++;
            $display("FAIL bad_write_port got g=%b en=%b we=%b exp 1 0 0", bus.l_gnt, bus.m_en, bus.m_we);
        end
        step();
        checks++;
        if ({bus.l_rvalid, bus.l_err, bus.l_rdata} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL bad_write_rsp got v=%b e=%b d=%h exp 1 1 0", bus.l_rvalid, bus.l_err, bus.l_rdata);
        end
        // Word 0 would be hit if the upper address bits were dropped.
        idle_inputs();
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h0;
        step();
        checks++;
        if ({bus.f_rvalid, bus.f_rdata} !== {1'b1, 32'hA000_0000}) begin
            errors++;
            $display("FAIL bad_write_mem got v=%b d=%h exp 1 a0000000", bus.f_rvalid, bus.f_rdata);
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_fetch_b2b();
        test_starvation();
        test_raw();
        test_misaligned();
        test_bad_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
